mrsc_encoder_pipe: RTL and testbench

//  Upstream stage of the MRSC path: encodes 16-bit data words into 32-bit MRSC codewords for mrsc_decoder.

---
 rtl/mrsc_encoder_pipe_pkg.sv | 50 +++++
 rtl/mrsc_encoder_pipe_if.sv | 21 ++
 rtl/mrsc_skid_buf.sv | 67 ++++++
 rtl/mrsc_encoder_pipe.sv | 65 ++++++
 tb/tb_mrsc_encoder_pipe.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mrsc_encoder_pipe_pkg.sv
// MRSC shared types, field offsets and the codeword encoder.
// Used by both the encoder pipe and mrsc_decoder.
package mrsc_pkg;

  typedef logic [15:0] mrsc_data_t;
  typedef logic [31:0] mrsc_word_t;

  localparam int DATA_LSB = 16;
  localparam int DIAG_LSB = 12;
  localparam int PAR_LSB  = 8;
  localparam int CHK_LSB  = 0;

  typedef enum logic {
    INJ_IDLE,
    INJ_ARMED
  } inj_state_e;

  // Nibble bit X1 is X[3], X4 is X[0].
  function automatic mrsc_word_t mrsc_encode(
    input mrsc_data_t d
  );
    logic [3:0] a, b, c, e;
    logic [3:0] diag, par;
    logic [7:0] chk;
    mrsc_word_t w;
    a = d[15:12];
    b = d[11:8];
    c = d[7:4];
    e = d[3:0];
    diag[3] = a[3] ^ b[2] ^ c[3] ^ e[2];
    diag[2] = a[1] ^ b[0] ^ c[1] ^ e[0];
    diag[1] = a[2] ^ b[3] ^ c[2] ^ e[3];
    diag[0] = a[0] ^ b[1] ^ c[0] ^ e[1];
    par[3]  = a[3] ^ b[3] ^ c[3] ^ e[3];
    par[2]  = a[1] ^ b[1] ^ c[1] ^ e[1];
    par[1]  = a[2] ^ b[2] ^ c[2] ^ e[2];
    par[0]  = a[0] ^ b[0] ^ c[0] ^ e[0];
    chk = {a[3] ^ a[1], a[2] ^ a[0],
           b[3] ^ b[1], b[2] ^ b[0],
           c[3] ^ c[1], c[2] ^ c[0],
           e[3] ^ e[1], e[2] ^ e[0]};
    w = '0;
    w[DATA_LSB +: 16] = d;
    w[DIAG_LSB +: 4]  = diag;
    w[PAR_LSB +: 4]   = par;
    w[CHK_LSB +: 8]   = chk;
    return w;
  endfunction

endpackage

// File: rtl/mrsc_encoder_pipe_if.sv
// Valid/ready stream bundle for the MRSC encoder pipe.
// master drives valid/data, slave drives ready.
interface mrsc_stream_if #(
  parameter int W = 16
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/mrsc_skid_buf.sv
// Two-entry valid/ready buffer: output register plus skid register.
// in_ready is registered and drops only when the skid entry is held.
module mrsc_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         ovld_q, ovld_d;
  logic         svld_q, svld_d;
  logic         rdy_q;
  logic [W-1:0] odat_q, odat_d;
  logic [W-1:0] sdat_q, sdat_d;
  logic         in_fire, out_free;

  assign in_fire  = in_valid_i & rdy_q;
  assign out_free = !ovld_q | out_ready_i;

  always_comb begin
    ovld_d = ovld_q;
    odat_d = odat_q;
    svld_d = svld_q;
    sdat_d = sdat_q;
    if (out_free) begin
      if (svld_q) begin
        ovld_d = 1'b1;
        odat_d = sdat_q;
        svld_d = in_fire;
        if (in_fire) sdat_d = in_data_i;
      end else begin
        ovld_d = in_fire;
        if (in_fire) odat_d = in_data_i;
      end
    end else if (in_fire) begin
      svld_d = 1'b1;
      sdat_d = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovld_q <= 1'b0;
      odat_q <= '0;
      svld_q <= 1'b0;
      sdat_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      ovld_q <= ovld_d;
      odat_q <= odat_d;
      svld_q <= svld_d;
      sdat_q <= sdat_d;
      rdy_q  <= !svld_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = ovld_q;
  assign out_data_o  = odat_q;

endmodule

// File: rtl/mrsc_encoder_pipe.sv
// MRSC encoder stage: 16-bit data in, 32-bit codeword out,
// skid-buffered, with a one-shot codeword corruption arm.
module mrsc_encoder_pipe
  import mrsc_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int INJECT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mrsc_stream_if.slave     in_if,
  mrsc_stream_if.master    out_if,
  input  logic             inj_arm,
  input  mrsc_word_t       inj_mask,
  output logic             inj_pending,
  output logic [CNT_W-1:0] word_count
);

  inj_state_e       state_q;
  mrsc_word_t       mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_fire, arm_en;
  mrsc_word_t       code;

  assign in_fire = in_if.valid & in_if.ready;
  assign arm_en  = (INJECT_EN != 0) & inj_arm;

  // A re-arm on the consuming beat keeps ARMED for the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INJ_IDLE;
      mask_q  <= '0;
    end else if (arm_en) begin
      state_q <= INJ_ARMED;
      mask_q  <= inj_mask;
    end else if (in_fire) begin
      state_q <= INJ_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (in_fire) cnt_q <= cnt_q + 1'b1;
  end

  assign code = mrsc_encode(in_if.data) ^
    ((state_q == INJ_ARMED) ? mask_q : '0);

  mrsc_skid_buf #(
    .W(32)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_if.valid),
    .in_ready_o (in_if.ready),
    .in_data_i  (code),
    .out_valid_o(out_if.valid),
    .out_ready_i(out_if.ready),
    .out_data_o (out_if.data)
  );

  assign inj_pending = (state_q == INJ_ARMED);
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_mrsc_encoder_pipe.sv
// Bench for mrsc_encoder_pipe: directed steps plus random traffic
// against a bit-rule reference encoder and a codeword queue.
module tb_mrsc_encoder_pipe;
  import mrsc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mrsc_stream_if #(16) in_s ();
  mrsc_stream_if #(32) out_s ();
  mrsc_stream_if #(16) in4 ();
  mrsc_stream_if #(32) out4 ();

  logic        arm;
  mrsc_word_t  mask;
  logic        pend, pend4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  mrsc_encoder_pipe u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_s),
    .out_if     (out_s),
    .inj_arm    (arm),
    .inj_mask   (mask),
    .inj_pending(pend),
    .word_count (cnt)
  );

  mrsc_encoder_pipe #(.CNT_W(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in4),
    .out_if     (out4),
    .inj_arm    (1'b0),
    .inj_mask   (32'h0),
    .inj_pending(pend4),
    .word_count (cnt4)
  );

  int checks = 0;
  int failures = 0;

  mrsc_word_t exp_q[$];
  int         m_count;
  bit         m_armed;
  mrsc_word_t m_mask;
  bit         prev_stall;
  mrsc_word_t prev_word;

  // Diagonal rows (bits 15..12): X index used for A,B,C,D.
  int dg[4][4] = '{'{1,2,1,2}, '{3,4,3,4},
                   '{2,1,2,1}, '{4,3,4,3}};
  // Parity rows (bits 11..8): X index shared by all nibbles.
  int pr[4] = '{1, 3, 2, 4};

  function automatic bit xb(mrsc_data_t d, int nib, int idx);
    return d[15 - 4*nib - (idx - 1)];
  endfunction

  function automatic mrsc_word_t ref_encode(mrsc_data_t d);
    mrsc_word_t w;
    bit p;
    w = '0;
    w[31:16] = d;
    for (int k = 0; k < 4; k++) begin
      p = 0;
      for (int n = 0; n < 4; n++) p ^= xb(d, n, dg[k][n]);
      w[15-k] = p;
      p = 0;
      for (int n = 0; n < 4; n++) p ^= xb(d, n, pr[k]);
      w[11-k] = p;
    end
    for (int n = 0; n < 4; n++) begin
      w[7-2*n] = xb(d, n, 1) ^ xb(d, n, 3);
      w[6-2*n] = xb(d, n, 2) ^ xb(d, n, 4);
    end
    return w;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic monitor();
    mrsc_word_t w;
    bit in_fire;
    if (prev_stall) begin
      chk("hold_valid", 32'(out_s.valid), 32'd1);
      chk("hold_word", out_s.data, prev_word);
    end
    chk("count", 32'(cnt), 32'(m_count[15:0]));
    chk("pending", 32'(pend), 32'(m_armed));
    if (out_s.valid && out_s.ready) begin
      if (exp_q.size() == 0)
        chk("spurious_out", 32'(exp_q.size()), 32'd1);
      else
        chk("out_word", out_s.data, exp_q.pop_front());
    end
    prev_stall = out_s.valid && !out_s.ready;
    prev_word  = out_s.data;
    in_fire = in_s.valid && in_s.ready;
    if (in_fire) begin
      w = ref_encode(in_s.data);
      if (m_armed) w ^= m_mask;
      exp_q.push_back(w);
      m_count++;
    end
    if (arm) begin
      m_armed = 1;
      m_mask  = mask;
    end else if (in_fire) begin
      m_armed = 0;
    end
  endtask

  task automatic step(bit v, mrsc_data_t d, bit r,
                      bit a, mrsc_word_t m);
    @(negedge clk);
    in_s.valid  = v;
    in_s.data   = d;
    out_s.ready = r;
    arm  = a;
    mask = m;
    #1;
    monitor();
  endtask

  initial begin
    rst_n = 1'b0;
    in_s.valid = 0; in_s.data = '0; out_s.ready = 1;
    in4.valid = 0;  in4.data = '0;  out4.ready = 1;
    arm = 0; mask = '0;
    m_count = 0; m_armed = 0; m_mask = '0;
    prev_stall = 0; prev_word = '0;

    // Reset values
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_s.ready), 32'd0);
    chk("rst_out_valid", 32'(out_s.valid), 32'd0);
    chk("rst_out_word", out_s.data, 32'h0);
    chk("rst_pending", 32'(pend), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_in_ready_low", 32'(in_s.ready), 32'd0);
    step(0, 16'h0, 1, 0, 0);
    chk("rel_in_ready_high", 32'(in_s.ready), 32'd1);

    // Zero word, one-cycle latency
    step(1, 16'h0000, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("zero_valid", 32'(out_s.valid), 32'd1);
    chk("zero_word", out_s.data, 32'h0000_0000);
    chk("zero_count", 32'(cnt), 32'd1);

    // Known vectors, back to back
    step(1, 16'hFFFF, 1, 0, 0);
    step(1, 16'h8000, 1, 0, 0);
    chk("vec_ffff", out_s.data, 32'hFFFF_0000);
    step(1, 16'h0001, 1, 0, 0);
    chk("vec_8000", out_s.data, 32'h8000_8880);
    step(0, 16'h0, 1, 0, 0);
    chk("vec_0001", out_s.data, 32'h0001_4101);
    step(0, 16'h0, 1, 0, 0);

    // Stall: two words held, in_ready low
    for (int i = 0; i < 5; i++)
      step(1, 16'($urandom), 0, 0, 0);
    chk("stall_in_ready", 32'(in_s.ready), 32'd0);
    chk("stall_out_valid", 32'(out_s.valid), 32'd1);
    chk("stall_held", 32'(exp_q.size()), 32'd2);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0, 0);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
    chk("stall_idle", 32'(out_s.valid), 32'd0);

    // One-shot injection
    step(0, 16'h0, 1, 1, 32'h0000_0001);
    step(1, 16'h0000, 1, 0, 0);
    chk("inj_pend_set", 32'(pend), 32'd1);
    step(1, 16'h0000, 1, 0, 0);
    chk("inj_word", out_s.data, 32'h0000_0001);
    chk("inj_pend_clr", 32'(pend), 32'd0);
    step(0, 16'h0, 1, 0, 0);
    chk("inj_next_clean", out_s.data, 32'h0000_0000);

    // Wrap of a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) chk("cnt4_wrap0", 32'(cnt4), 32'd0);
      in4.valid = 1;
    end
    @(negedge clk); in4.valid = 0; #1;
    chk("cnt4_wrap1", 32'(cnt4), 32'd1);

    // Reset with two words held
    step(1, 16'h1234, 0, 0, 0);
    step(1, 16'h5678, 0, 0, 0);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", 32'(out_s.valid), 32'd0);
    chk("mid_rst_count", 32'(cnt), 32'd0);
    chk("mid_rst_ready", 32'(in_s.ready), 32'd0);
    exp_q.delete();
    m_count = 0; m_armed = 0; prev_stall = 0;
    in_s.valid = 0; out_s.ready = 1;
    @(negedge clk); rst_n = 1'b1;
    step(0, 16'h0, 1, 0, 0);
    step(1, 16'h8000, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("post_rst_word", out_s.data, 32'h8000_8880);

    // Random traffic with occasional arming
    for (int i = 0; i < 10000; i++)
      step(1'($urandom), 16'($urandom),
           ($urandom % 4) != 0, ($urandom % 64) == 0,
           32'($urandom));
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      step(0, 16'h0, 1, 0, 0);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
